// File: rtl/audio_pcm_pkg.sv
// Shared audio PCM helpers: CIC order, CIC accumulator width, signed saturation.
package audio_pcm_pkg;

    localparam int CIC_ORDER = 3;

    function automatic int cic_w_acc(input int w_in, input int log_dec);
        return w_in + 1 + CIC_ORDER * log_dec;
    endfunction

    // Clamp v to the signed range of a w-bit word; caller truncates to w bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/audio_dc_block.sv
// First-order DC blocker with saturated output; one clock of latency per accepted sample.
module audio_dc_block
    import audio_pcm_pkg::*;
#(
    parameter int W        = 16,
    parameter int DC_SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    input  logic signed [W-1:0] in,
    output logic                out_vld,
    output logic signed [W-1:0] out
);

    localparam int WZ = W + DC_SHIFT;

    logic signed [WZ-1:0] z_r;
    logic signed [WZ-1:0] z_nxt_s;
    logic signed [W-1:0]  prev_r;
    logic                 out_vld_r;
    logic signed [W-1:0]  out_r;

    assign z_nxt_s = WZ'(in) - WZ'(prev_r) + z_r - (z_r >>> DC_SHIFT);

    // Filter state and registered saturated output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_r       <= '0;
            prev_r    <= '0;
            out_vld_r <= 1'b0;
            out_r     <= '0;
        end else begin
            out_vld_r <= in_vld;
            if (in_vld) begin
                prev_r <= in;
                z_r    <= z_nxt_s;
                out_r  <= W'(sat_signed(64'(z_nxt_s), W));
            end
        end
    end

    assign out_vld = out_vld_r;
    assign out     = out_r;

endmodule

// File: rtl/audio_pdm_cic_decimator.sv
// PDM to PCM: third-order CIC decimator, saturating rescale, 1-entry valid/ready buffer.
// Define AUDIO_PDM_DCBLOCK_EN to insert audio_dc_block ahead of the output buffer.
module audio_pdm_cic_decimator
    import audio_pcm_pkg::*;
#(
    parameter int W_IN         = 1,
    parameter int W_OUT        = 16,
    parameter int LOG_DECIMATE = 5,
    parameter int DC_SHIFT     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic [W_IN-1:0]         pdm_in,
    output logic signed [W_OUT-1:0] sample_out,
    output logic                    sample_out_vld,
    input  logic                    sample_out_rdy,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int W_ACC = cic_w_acc(W_IN, LOG_DECIMATE);
    localparam int SHIFT = W_IN + CIC_ORDER * LOG_DECIMATE - W_OUT;

    if (SHIFT < 0 || DC_SHIFT < 1) begin : g_bad_cfg
        $error("audio_pdm_cic_decimator: unsupported parameter combination");
    end

    logic signed [W_ACC-1:0]    x_s, i1_r, i2_r, i3_r;
    logic signed [W_ACC-1:0]    d1_r, d2_r, d3_r, c1_s, c2_s, c3_s, c3_r;
    logic [LOG_DECIMATE-1:0]    cnt_r;
    logic                       strobe_s;
    logic [1:0]                 settle_r;
    logic                       comb_vld_r;
    logic signed [W_OUT-1:0]    y_s, y_r;
    logic                       y_vld_r;
    logic                       buf_vld_s;
    logic signed [W_OUT-1:0]    buf_in_s;
    logic signed [W_OUT-1:0]    sample_r;
    logic                       vld_r;
    logic                       overrun_r;

    // Unsigned PDM code mapped to odd symmetric levels: 2*code - (2^W_IN - 1)
    assign x_s = $signed({{(W_ACC-W_IN-1){1'b0}}, pdm_in, 1'b0})
               - $signed(W_ACC'((64'd1 << W_IN) - 64'd1));

    assign strobe_s = clk_en && (&cnt_r);
    assign c1_s     = i3_r - d1_r;
    assign c2_s     = c1_s - d2_r;
    assign c3_s     = c2_s - d3_r;
    assign y_s      = W_OUT'(sat_signed((64'(c3_r)) >>> SHIFT, W_OUT));

    // Integrators and decimation counter; wrap-around is harmless for CIC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_r  <= '0;
            i2_r  <= '0;
            i3_r  <= '0;
            cnt_r <= '0;
        end else if (clk_en) begin
            i1_r  <= i1_r + x_s;
            i2_r  <= i2_r + i1_r;
            i3_r  <= i3_r + i2_r;
            cnt_r <= cnt_r + LOG_DECIMATE'(1);
        end
    end

    // Comb section at the decimated rate; first three results are warm-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r       <= '0;
            d2_r       <= '0;
            d3_r       <= '0;
            c3_r       <= '0;
            settle_r   <= 2'd0;
            comb_vld_r <= 1'b0;
        end else begin
            comb_vld_r <= 1'b0;
            if (strobe_s) begin
                d1_r <= i3_r;
                d2_r <= c1_s;
                d3_r <= c2_s;
                c3_r <= c3_s;
                if (settle_r == 2'd3) begin
                    comb_vld_r <= 1'b1;
                end else begin
                    settle_r <= settle_r + 2'd1;
                end
            end
        end
    end

    // Rescale and saturate stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r     <= '0;
            y_vld_r <= 1'b0;
        end else begin
            y_vld_r <= comb_vld_r;
            if (comb_vld_r) begin
                y_r <= y_s;
            end
        end
    end

`ifdef AUDIO_PDM_DCBLOCK_EN
    audio_dc_block #(
        .W        (W_OUT),
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_block (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (y_vld_r),
        .in      (y_r),
        .out_vld (buf_vld_s),
        .out     (buf_in_s)
    );
`else
    assign buf_vld_s = y_vld_r;
    assign buf_in_s  = y_r;
`endif

    // Output buffer: load when empty or popping; otherwise drop and flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r  <= '0;
            vld_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (buf_vld_s && (!vld_r || sample_out_rdy)) begin
                sample_r <= buf_in_s;
                vld_r    <= 1'b1;
            end else if (vld_r && sample_out_rdy) begin
                vld_r <= 1'b0;
            end
            if (overrun_clr) begin
                overrun_r <= 1'b0;
            end else if (buf_vld_s && vld_r && !sample_out_rdy) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign sample_out     = sample_r;
    assign sample_out_vld = vld_r;
    assign overrun        = overrun_r;

endmodule
